decode38_hold: RTL and testbench

Registered 3-to-8 decoder with a valid/ready input handshake and a programmable hold time. It is the receive-side counterpart of the 8-to-3 priority encoder. Each accepted 3-bit code drives exactly one bit of `y` high for `HOLD_CYCLES` cycles and shows the code on an active-low seven-segment digit. It sits between the encoder/keypad path and the LED/segment outputs of the board top.

---
 rtl/decode38_pkg.sv | 14 +
 rtl/decode38_hold_seg7.sv | 11 +
 rtl/decode38_hold.sv | 97 +++++++++
 tb/tb_decode38_hold.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/decode38_pkg.sv
// Shared types and constants for the registered 3-to-8 decoder with hold.
package decode38_pkg;

  typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} dec_state_t;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Active-low {g,f,e,d,c,b,a}; index 7 is the leftmost entry.
  localparam logic [7:0][6:0] SEG_LUT = {
    7'b1111000, 7'b0000010, 7'b0010010, 7'b0011001,
    7'b0110000, 7'b0100100, 7'b1111001, 7'b1000000
  };

endpackage

// File: rtl/decode38_hold_seg7.sv
// Combinational 3-bit code to active-low seven-segment lookup.
module seg7_dec
  import decode38_pkg::*;
(
  input  logic [2:0] code,
  output logic [6:0] seg
);

  assign seg = SEG_LUT[code];

endmodule

// File: rtl/decode38_hold.sv
// Registered 3-to-8 decoder: each accepted code drives one y bit for HOLD_CYCLES
// cycles, with back-to-back reload on the final hold cycle.
module decode38_hold
  import decode38_pkg::*;
#(
  parameter int HOLD_CYCLES = 4,
  parameter int CNT_W       = $clog2(HOLD_CYCLES) + 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [2:0] code,
  output logic [7:0] y,
  output logic       busy,
  output logic       done,
  output logic [6:0] seg
);

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(HOLD_CYCLES - 1);

  dec_state_t       state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [7:0]       y_nxt;
  logic [2:0]       code_q, code_nxt;
  logic             done_nxt;
  logic             accept;
  logic [6:0]       seg_raw;

  assign in_ready = en && ((state == IDLE) || (cnt == '0));
  assign accept   = in_valid && in_ready;
  assign busy     = (state == HOLD);

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      y      <= '0;
      code_q <= '0;
      done   <= 1'b0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      y      <= y_nxt;
      code_q <= code_nxt;
      done   <= done_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    y_nxt     = y;
    code_nxt  = code_q;
    done_nxt  = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          y_nxt     = 8'd1 << code;
          code_nxt  = code;
          cnt_nxt   = CNT_LOAD;
          state_nxt = HOLD;
        end
      end
      HOLD: begin
        // Dropping en aborts silently, ahead of expiry and reload.
        if (!en) begin
          y_nxt     = '0;
          cnt_nxt   = '0;
          state_nxt = IDLE;
        end else if (cnt != '0) begin
          cnt_nxt = cnt - 1'b1;
        end else begin
          done_nxt = 1'b1;
          if (accept) begin
            y_nxt    = 8'd1 << code;
            code_nxt = code;
            cnt_nxt  = CNT_LOAD;
          end else begin
            y_nxt     = '0;
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  seg7_dec u_seg (
    .code (code_q),
    .seg  (seg_raw)
  );

  assign seg = busy ? seg_raw : SEG_BLANK;

endmodule

// File: tb/tb_decode38_hold.sv
// Scoreboard bench: two decoders (HOLD_CYCLES 4 and 1) share stimulus; a
// hold-time reference model predicts per-cycle outputs, a monitor compares.
module tb_decode38_hold;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic       in_valid = 1'b0;
  logic [2:0] code = 3'd0;

  logic       rdy4, busy4, done4, rdy1, busy1, done1;
  logic [7:0] y4, y1;
  logic [6:0] seg4, seg1;

  always #5 clk = ~clk;

  decode38_hold #(.HOLD_CYCLES(4)) dut4 (
    .clk(clk), .rst(rst), .en(en), .in_valid(in_valid), .in_ready(rdy4),
    .code(code), .y(y4), .busy(busy4), .done(done4), .seg(seg4)
  );

  decode38_hold #(.HOLD_CYCLES(1)) dut1 (
    .clk(clk), .rst(rst), .en(en), .in_valid(in_valid), .in_ready(rdy1),
    .code(code), .y(y1), .busy(busy1), .done(done1), .seg(seg1)
  );

  typedef struct {
    logic [7:0] y;
    logic [6:0] seg;
    bit         busy;
    bit         done;
    bit         rdy;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];

  logic [6:0] pat[8] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                         7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000};

  // Model: shown = cycles the current code has been displayed (0 = idle).
  int         hv[2] = '{4, 1};
  int         shown[2] = '{0, 0};
  logic [2:0] cur[2];
  bit         dn[2] = '{1'b0, 1'b0};

  int n_chk = 0;
  int n_fail = 0;

  task automatic step(input int k);
    bit r, acc;
    r   = en && (shown[k] == 0 || shown[k] == hv[k]);
    acc = in_valid && r;
    dn[k] = 1'b0;
    if (rst || !en) begin
      shown[k] = 0;
    end else if (shown[k] == hv[k]) begin
      dn[k] = 1'b1;
      if (acc) begin cur[k] = code; shown[k] = 1; end
      else shown[k] = 0;
    end else if (shown[k] > 0) begin
      shown[k]++;
    end else if (acc) begin
      cur[k] = code;
      shown[k] = 1;
    end
  endtask

  function automatic exp_t predict(input int k);
    exp_t e;
    e.y    = (shown[k] > 0) ? (8'd1 << cur[k]) : 8'd0;
    e.seg  = (shown[k] > 0) ? pat[cur[k]] : 7'h7F;
    e.busy = shown[k] > 0;
    e.done = dn[k];
    e.rdy  = en && (shown[k] == 0 || shown[k] == hv[k]);
    return e;
  endfunction

  // One clock: advance the model on the edge, then drive the next inputs.
  task automatic cycle(input bit r, input bit e, input bit v, input int c);
    @(posedge clk);
    step(0);
    step(1);
    #1;
    rst = r; en = e; in_valid = v; code = 3'(c);
    q0.push_back(predict(0));
    q1.push_back(predict(1));
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (q0.size() > 0) begin
      e = q0.pop_front();
      chk("h4.y", y4, e.y);
      chk("h4.seg", seg4, e.seg);
      chk("h4.busy", busy4, e.busy);
      chk("h4.done", done4, e.done);
      chk("h4.in_ready", rdy4, e.rdy);
    end
    if (q1.size() > 0) begin
      e = q1.pop_front();
      chk("h1.y", y1, e.y);
      chk("h1.seg", seg1, e.seg);
      chk("h1.busy", busy1, e.busy);
      chk("h1.done", done1, e.done);
      chk("h1.in_ready", rdy1, e.rdy);
    end
  end

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, 1, 0, 0);
  endtask

  initial begin
    cycle(1, 0, 0, 0);
    cycle(1, 0, 0, 0);
    idle(1);
    // single code, full hold then done
    cycle(0, 1, 1, 5);
    idle(7);
    // sweep every code from idle
    for (int c = 0; c < 8; c++) begin
      cycle(0, 1, 1, c);
      idle(6);
    end
    // back-to-back 3 then 6 with valid held
    cycle(0, 1, 1, 3);
    for (int i = 0; i < 5; i++) cycle(0, 1, 1, 6);
    idle(6);
    // abort by dropping en on the 2nd hold cycle
    cycle(0, 1, 1, 2);
    cycle(0, 1, 0, 2);
    cycle(0, 0, 1, 2);
    cycle(0, 0, 1, 2);
    idle(5);
    // reset mid-hold
    cycle(0, 1, 1, 7);
    cycle(0, 1, 0, 0);
    cycle(1, 1, 0, 0);
    idle(3);
    // continuous stream
    cycle(0, 1, 1, 0);
    cycle(0, 1, 1, 1);
    cycle(0, 1, 1, 2);
    idle(6);
    // randomized traffic
    for (int i = 0; i < 600; i++)
      cycle(($urandom % 60) == 0, ($urandom % 8) != 0, $urandom % 2, $urandom % 8);
    idle(8);
    @(negedge clk);
    @(negedge clk);
    chk("queue_drain", q0.size() + q1.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
